// File: rtl/simple_cpu_param_if.sv
// Memory bus between the CPU (master) and a RAM (slave).
interface simple_cpu_param_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 13
);
   logic          mem_req;
   logic          mem_rdy;
   logic          wrEn;
   logic [AW-1:0] addr_toRAM;
   logic [DW-1:0] data_toRAM;
   logic [DW-1:0] data_fromRAM;

   modport master (
      output mem_req, wrEn, addr_toRAM, data_toRAM,
      input  mem_rdy, data_fromRAM
   );

   modport slave (
      input  mem_req, wrEn, addr_toRAM, data_toRAM,
      output mem_rdy, data_fromRAM
   );
endinterface

// File: rtl/simple_cpu_param.sv
// Accumulator CPU: one memory operand per instruction, optional indirection through
// a fixed pointer location, and a req/rdy memory bus that may stall indefinitely.
module simple_cpu_param #(
   parameter int unsigned DW       = 16,
   parameter int unsigned AW       = 13,
   parameter int unsigned PTR_ADDR = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   simple_cpu_param_if.master   bus,
   output logic [AW-1:0]        PC,
   output logic [DW-1:0]        W,
   output logic                 retire
);

   typedef enum logic [2:0] {StIf, StPtr, StOp, StEx, StWb} state_e;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_SRL  = 3'd2;
   localparam logic [2:0] OP_RRL  = 3'd3;
   localparam logic [2:0] OP_CMP  = 3'd4;
   localparam logic [2:0] OP_BZ   = 3'd5;
   localparam logic [2:0] OP_CP2W = 3'd6;
   localparam logic [2:0] OP_CPFW = 3'd7;

   localparam logic [DW:0]   LP_DW_X  = (DW+1)'(DW);
   localparam logic [DW:0]   LP_2DW_X = (DW+1)'(2 * DW);
   localparam logic [DW-1:0] LP_DW    = DW'(DW);
   localparam logic [AW-1:0] LP_PTR   = AW'(PTR_ADDR);

   state_e        r_state, w_next;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_w;
   logic [2:0]    r_ir;      // only the opcode field of IR is needed after fetch
   logic [AW-1:0] r_ea;
   logic [DW-1:0] r_v;

   logic [2:0]      w_opcode;
   logic [AW-1:0]   w_a;
   logic [DW-1:0]   w_amt;
   logic            w_right;
   logic [2*DW-1:0] w_dbl;
   logic [DW-1:0]   w_alu;
   logic [AW-1:0]   w_pc_ex;

   assign w_opcode = bus.data_fromRAM[DW-1:DW-3];
   assign w_a      = bus.data_fromRAM[AW-1:0];
   assign w_dbl    = {r_w, r_w};
   assign PC       = r_pc;
   assign W        = r_w;

   // Shift/rotate amount and direction from the operand's range
   always_comb begin
      w_amt   = r_v;
      w_right = 1'b1;
      if ({1'b0, r_v} < LP_DW_X) begin
         w_amt   = r_v;
         w_right = 1'b1;
      end else if ({1'b0, r_v} < LP_2DW_X) begin
         w_amt   = r_v - LP_DW;
         w_right = 1'b0;
      end else begin
         w_amt   = r_v % LP_DW;
         w_right = 1'b0;
      end
   end

   // Execute-stage result for W and PC
   always_comb begin
      w_alu   = r_w;
      w_pc_ex = r_pc + AW'(1);
      case (r_ir)
         OP_ADD:  w_alu = r_w + r_v;
         OP_NOR:  w_alu = ~(r_w | r_v);
         OP_SRL:  w_alu = w_right ? (r_w >> w_amt) : (r_w << w_amt);
         OP_RRL:  w_alu = w_right ? DW'(w_dbl >> w_amt) : DW'((w_dbl << w_amt) >> DW);
         OP_CMP: begin
            if (r_w < r_v)       w_alu = '1;
            else if (r_w == r_v) w_alu = '0;
            else                 w_alu = DW'(1);
         end
         OP_BZ: begin
            if (r_v == '0) w_pc_ex = r_w[AW-1:0];
         end
         OP_CP2W: w_alu = r_v;
         default: w_alu = r_w;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= StIf;
      else      r_state <= w_next;
   end

   // Next-state decode; every memory state waits for mem_rdy
   always_comb begin
      w_next = r_state;
      case (r_state)
         StIf: begin
            if (bus.mem_rdy) begin
               if (w_a == '0)             w_next = StPtr;
               else if (w_opcode == OP_CPFW) w_next = StWb;
               else                       w_next = StOp;
            end
         end
         StPtr: begin
            if (bus.mem_rdy) w_next = (r_ir == OP_CPFW) ? StWb : StOp;
         end
         StOp: begin
            if (bus.mem_rdy) w_next = StEx;
         end
         StEx: w_next = StIf;
         StWb: begin
            if (bus.mem_rdy) w_next = StIf;
         end
         default: w_next = StIf;
      endcase
   end

   // Bus request and retire outputs; all forced low while in reset
   always_comb begin
      bus.mem_req    = 1'b0;
      bus.wrEn       = 1'b0;
      bus.addr_toRAM = '0;
      bus.data_toRAM = '0;
      retire         = 1'b0;
      if (rst) begin
         case (r_state)
            StIf: begin
               bus.mem_req    = 1'b1;
               bus.addr_toRAM = r_pc;
            end
            StPtr: begin
               bus.mem_req    = 1'b1;
               bus.addr_toRAM = LP_PTR;
            end
            StOp: begin
               bus.mem_req    = 1'b1;
               bus.addr_toRAM = r_ea;
            end
            StEx: retire = 1'b1;
            StWb: begin
               bus.mem_req    = 1'b1;
               bus.wrEn       = 1'b1;
               bus.addr_toRAM = r_ea;
               bus.data_toRAM = r_w;
               retire         = bus.mem_rdy;
            end
            default: retire = 1'b0;
         endcase
      end
   end

   // Datapath registers; RAM data only ever lands in registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= '0;
         r_w  <= '0;
         r_ir <= '0;
         r_ea <= '0;
         r_v  <= '0;
      end else begin
         case (r_state)
            StIf: begin
               if (bus.mem_rdy) begin
                  r_ir <= w_opcode;
                  r_ea <= w_a;
               end
            end
            StPtr: begin
               if (bus.mem_rdy) r_ea <= bus.data_fromRAM[AW-1:0];
            end
            StOp: begin
               if (bus.mem_rdy) r_v <= bus.data_fromRAM;
            end
            StEx: begin
               r_w  <= w_alu;
               r_pc <= w_pc_ex;
            end
            StWb: begin
               if (bus.mem_rdy) r_pc <= r_pc + AW'(1);
            end
            default: r_pc <= r_pc;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_cpu_param.sv
// Bench for simple_cpu_param: RAM model, directed programs, retire scoreboard.
module tb_simple_cpu_param;

   localparam logic [2:0] ADD = 3'd0, NOR = 3'd1, SRL = 3'd2, RRL = 3'd3;
   localparam logic [2:0] CMP = 3'd4, BZ = 3'd5, CP2W = 3'd6, CPFW = 3'd7;

   typedef struct {
      logic [12:0] pc;
      logic [15:0] w;
      int          lat;
      bit          is_ex;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] PC;
   logic [15:0] W;
   logic        retire;

   logic [15:0] mem [0:8191];
   exp_t        sb[$];
   logic [12:0] rd_log[$];
   int          wr_cnt;
   int          retired;
   int          errors = 0;
   int          checks = 0;

   simple_cpu_param_if #(.DW(16), .AW(13)) bus ();

   simple_cpu_param #(.DW(16), .AW(13), .PTR_ADDR(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .PC     (PC),
      .W      (W),
      .retire (retire)
   );

   always #5 clk = ~clk;

   assign bus.data_fromRAM = mem[bus.addr_toRAM];

   // RAM: commit writes and log reads on completed handshakes
   always @(posedge clk) begin
      if (rst && bus.mem_req && bus.mem_rdy) begin
         if (bus.wrEn) begin
            mem[bus.addr_toRAM] = bus.data_toRAM;
            wr_cnt++;
         end else begin
            rd_log.push_back(bus.addr_toRAM);
         end
      end
   end

   function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] a);
      return {op, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ret(input logic [12:0] pc, input logic [15:0] w, input int lat,
                             input bit is_ex);
      exp_t e;
      e.pc = pc; e.w = w; e.lat = lat; e.is_ex = is_ex;
      sb.push_back(e);
   endtask

   task automatic begin_test();
      rst = 1'b0;
      bus.mem_rdy = 1'b1;
      for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
      sb.delete();
      rd_log.delete();
      wr_cnt  = 0;
      retired = 0;
   endtask

   task automatic go();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic run(input int n);
      int k = 0;
      while (retired < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("retire_count", 32'(retired), 32'(n));
   endtask

   // Monitor: pop the expected retire, check latency and the post-edge PC/W
   initial begin
      int   cyc = 0;
      int   last = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cyc  = 0;
            last = 0;
         end else begin
            cyc++;
            if (retire) begin
               if (sb.size() == 0) begin
                  chk("unexpected_retire", 32'(PC), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk("latency", 32'(cyc - last), 32'(e.lat));
                  last = cyc;
                  if (e.is_ex)
                     chk("idle_bus", 32'({bus.mem_req, bus.wrEn, bus.addr_toRAM,
                                          bus.data_toRAM}), 32'h0);
                  @(posedge clk);
                  #1;
                  chk("pc", 32'(PC), 32'(e.pc));
                  chk("w", 32'(W), 32'(e.w));
                  retired++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.mem_rdy = 1'b1;
      wr_cnt = 0;
      retired = 0;
      #2 rst = 1'b0;
      #1;
      chk("reset_pc", 32'(PC), 32'h0);
      chk("reset_w", 32'(W), 32'h0);
      chk("reset_bus", 32'({bus.mem_req, bus.wrEn, bus.addr_toRAM, bus.data_toRAM,
                            retire}), 32'h0);

      // Direct ADD
      begin_test();
      mem[0] = ins(ADD, 13'd10); mem[10] = 16'd5;
      expect_ret(13'd1, 16'd5, 3, 1'b1);
      go();
      run(1);

      // Indirect/direct operand fetch and both CPfW forms
      begin_test();
      mem[0] = ins(CP2W, 13'd0); mem[1] = ins(CPFW, 13'd40);
      mem[2] = ins(ADD, 13'd10); mem[3] = ins(CPFW, 13'd0);
      mem[4] = 16'd20; mem[20] = 16'd3; mem[10] = 16'd5;
      expect_ret(13'd1, 16'd3, 4, 1'b1);
      expect_ret(13'd2, 16'd3, 2, 1'b0);
      expect_ret(13'd3, 16'd8, 3, 1'b1);
      expect_ret(13'd4, 16'd8, 3, 1'b0);
      go();
      run(4);
      chk("rd0", 32'(rd_log[0]), 32'd0);
      chk("rd1", 32'(rd_log[1]), 32'd4);
      chk("rd2", 32'(rd_log[2]), 32'd20);
      chk("mem40", 32'(mem[40]), 32'd3);
      chk("mem20", 32'(mem[20]), 32'd8);
      chk("wr_cnt2", 32'(wr_cnt), 32'd2);

      // Shifts, rotates, NOR, ADD wrap
      begin_test();
      mem[0]  = ins(CP2W, 13'd20); mem[1]  = ins(SRL, 13'd21);
      mem[2]  = ins(CP2W, 13'd20); mem[3]  = ins(RRL, 13'd22);
      mem[4]  = ins(CP2W, 13'd20); mem[5]  = ins(SRL, 13'd23);
      mem[6]  = ins(CP2W, 13'd20); mem[7]  = ins(RRL, 13'd24);
      mem[8]  = ins(RRL, 13'd25);  mem[9]  = ins(SRL, 13'd26);
      mem[10] = ins(RRL, 13'd27);  mem[11] = ins(NOR, 13'd28);
      mem[12] = ins(ADD, 13'd29);
      mem[20] = 16'h8001; mem[21] = 16'd17; mem[22] = 16'd1; mem[23] = 16'd35;
      mem[24] = 16'd18; mem[25] = 16'd0; mem[26] = 16'd2; mem[27] = 16'd33;
      mem[28] = 16'h00F0; mem[29] = 16'h00F3;
      expect_ret(13'd1,  16'h8001, 3, 1'b1);
      expect_ret(13'd2,  16'h0002, 3, 1'b1);
      expect_ret(13'd3,  16'h8001, 3, 1'b1);
      expect_ret(13'd4,  16'hC000, 3, 1'b1);
      expect_ret(13'd5,  16'h8001, 3, 1'b1);
      expect_ret(13'd6,  16'h0008, 3, 1'b1);
      expect_ret(13'd7,  16'h8001, 3, 1'b1);
      expect_ret(13'd8,  16'h0006, 3, 1'b1);
      expect_ret(13'd9,  16'h0006, 3, 1'b1);
      expect_ret(13'd10, 16'h0001, 3, 1'b1);
      expect_ret(13'd11, 16'h0002, 3, 1'b1);
      expect_ret(13'd12, 16'hFF0D, 3, 1'b1);
      expect_ret(13'd13, 16'h0000, 3, 1'b1);
      go();
      run(13);

      // CMP sweep and BZ taken / not taken
      begin_test();
      mem[0] = ins(CP2W, 13'd20); mem[1] = ins(CMP, 13'd21);
      mem[2] = ins(CP2W, 13'd20); mem[3] = ins(CMP, 13'd22);
      mem[4] = ins(CP2W, 13'd20); mem[5] = ins(CMP, 13'd23);
      mem[6] = ins(CP2W, 13'd24); mem[7] = ins(BZ, 13'd25);
      mem[13'h123] = ins(BZ, 13'd26);
      mem[20] = 16'd7; mem[21] = 16'd8; mem[22] = 16'd7; mem[23] = 16'd6;
      mem[24] = 16'h0123; mem[25] = 16'd0; mem[26] = 16'd5;
      expect_ret(13'd1, 16'h0007, 3, 1'b1);
      expect_ret(13'd2, 16'hFFFF, 3, 1'b1);
      expect_ret(13'd3, 16'h0007, 3, 1'b1);
      expect_ret(13'd4, 16'h0000, 3, 1'b1);
      expect_ret(13'd5, 16'h0007, 3, 1'b1);
      expect_ret(13'd6, 16'h0001, 3, 1'b1);
      expect_ret(13'd7, 16'h0123, 3, 1'b1);
      expect_ret(13'h123, 16'h0123, 3, 1'b1);
      expect_ret(13'h124, 16'h0123, 3, 1'b1);
      go();
      run(9);

      // CPfW with a five-cycle write stall
      begin_test();
      mem[0] = ins(CP2W, 13'd20); mem[1] = ins(CPFW, 13'd30); mem[20] = 16'hBEEF;
      expect_ret(13'd1, 16'hBEEF, 3, 1'b1);
      expect_ret(13'd2, 16'hBEEF, 7, 1'b0);
      go();
      run(1);
      @(posedge clk);
      #1 bus.mem_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("wb_hold", 32'({bus.mem_req, bus.wrEn, bus.addr_toRAM, bus.data_toRAM}),
             32'({1'b1, 1'b1, 13'd30, 16'hBEEF}));
         chk("wb_pc_hold", 32'(PC), 32'd1);
      end
      @(posedge clk);
      #1 bus.mem_rdy = 1'b1;
      run(2);
      chk("stall_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("mem30", 32'(mem[30]), 32'hBEEF);

      // Reset during a stalled write
      begin_test();
      mem[0] = ins(CP2W, 13'd20); mem[1] = ins(CPFW, 13'd31); mem[20] = 16'h1234;
      expect_ret(13'd1, 16'h1234, 3, 1'b1);
      go();
      run(1);
      @(posedge clk);
      #1 bus.mem_rdy = 1'b0;
      @(negedge clk);
      chk("wb_req", 32'({bus.mem_req, bus.wrEn}), 32'h3);
      @(negedge clk);
      #1 rst = 1'b0;
      bus.mem_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pc", 32'(PC), 32'h0);
      chk("rst_w", 32'(W), 32'h0);
      chk("rst_req", 32'({bus.mem_req, bus.wrEn}), 32'h0);
      chk("rst_no_write", 32'(wr_cnt), 32'd0);
      chk("rst_mem31", 32'(mem[31]), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("refetch", 32'({bus.mem_req, bus.wrEn, bus.addr_toRAM}), 32'({1'b1, 1'b0, 13'd0}));
      #1 rst = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
